spi_ram_host_ctrl: RTL and testbench

SPI_RAM_HOST_CTRL -- requirements
Module: spi_ram_host_ctrl

---
 rtl/spi_ram_host_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spi_ram_host_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_host_ctrl.sv
// Host-side sequencer for a bit-serial SPI slave fronting a byte RAM.
// Each request becomes two 11-bit frames; reads add a turnaround and an 8-bit MISO capture.
`timescale 1ns/1ps
module spi_ram_host_ctrl #(
  parameter int GAP_CYCLES = 1,
  parameter int RD_WAIT    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       wr_done,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {IDLE, CMD, SHIFT, GAP, WAIT, CAPT, DONE} state_e;

  localparam logic [7:0] GAP_M1 = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] GAP_M2 = (GAP_CYCLES >= 2) ? 8'(GAP_CYCLES - 2) : 8'd0;
  localparam logic [7:0] RDW_M1 = 8'(RD_WAIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [9:0] word_q, word_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] hold_q, hold_d;
  logic       wr_q, wr_d;
  logic       phase_q, phase_d;
  logic       accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      wr_q    <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      phase_q <= phase_d;
    end
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    sh_d    = sh_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    wr_d    = wr_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
      CMD: begin
        state_d = SHIFT;
        cnt_d   = 8'd9;
      end
      SHIFT: begin
        word_d = {word_q[8:0], 1'b0};
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else if (!phase_q) begin
          state_d = GAP;
          cnt_d   = GAP_M1;
        end else if (wr_q) state_d = DONE;
        else begin
          state_d = WAIT;
          cnt_d   = RDW_M1;
        end
      end
      GAP: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else begin
          state_d = CMD;
          phase_d = 1'b1;
          word_d  = wr_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else begin
          state_d = CAPT;
          cnt_d   = 8'd7;
        end
      end
      CAPT: begin
        sh_d = {sh_q[6:0], MISO};
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else begin
          state_d = DONE;
          rdata_d = {sh_q[6:0], MISO};
        end
      end
      DONE: begin
        state_d = IDLE;
        hold_d  = GAP_M2;
      end
      default: state_d = IDLE;
    endcase
    // A new request may start from IDLE or, with a one-cycle gap, straight from DONE.
    if (accept) begin
      state_d = CMD;
      wr_d    = req_wr;
      wdata_d = req_wdata;
      phase_d = 1'b0;
      word_d  = {(req_wr ? 2'b00 : 2'b10), req_addr};
    end
  end

  always_comb begin
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    rsp_valid = 1'b0;
    wr_done   = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: req_ready = (hold_q == 8'd0) && !reset;
      CMD: begin
        SS_n = 1'b0;
        MOSI = !wr_q;
      end
      SHIFT: begin
        SS_n = 1'b0;
        MOSI = word_q[9];
      end
      WAIT, CAPT: SS_n = 1'b0;
      DONE: begin
        rsp_valid = !wr_q;
        wr_done   = wr_q;
        req_ready = (GAP_CYCLES <= 1) && !reset;
      end
      default: ;
    endcase
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_ram_host_ctrl.sv
// Directed bench: two controllers (default and RD_WAIT=3/GAP_CYCLES=2) each talking
// to a behavioural SPI RAM slave that logs frames and SS_n-high gaps.
`timescale 1ns/1ps
module tb_spi_ram_host_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rv[2], rw[2], rdy[2], vr[2], wd[2], ssn[2], mosi[2], miso[2];
  logic [7:0] ra[2], rd[2], rdat[2];

  always #5 clk = ~clk;

  spi_ram_host_ctrl dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]), .req_wr(rw[0]),
    .req_addr(ra[0]), .req_wdata(rd[0]), .rsp_valid(vr[0]), .rsp_rdata(rdat[0]),
    .wr_done(wd[0]), .SS_n(ssn[0]), .MOSI(mosi[0]), .MISO(miso[0]));

  spi_ram_host_ctrl #(.GAP_CYCLES(2), .RD_WAIT(3)) dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]), .req_wr(rw[1]),
    .req_addr(ra[1]), .req_wdata(rd[1]), .rsp_valid(vr[1]), .rsp_rdata(rdat[1]),
    .wr_done(wd[1]), .SS_n(ssn[1]), .MOSI(mosi[1]), .MISO(miso[1]));

  // Slave model state (written only by the model process)
  int          idx[2]      = '{default: 0};
  int          fcnt[2]     = '{default: 0};
  int          gcnt[2]     = '{default: 0};
  int          hi_run[2]   = '{default: 0};
  int          mosi_bad[2] = '{default: 0};
  int          both_bad[2] = '{default: 0};
  int          nvr[2]      = '{default: 0};
  int          nwd[2]      = '{default: 0};
  bit          seen[2]     = '{default: 1'b0};
  logic [10:0] fb[2];
  logic [7:0]  maddr[2];
  logic [10:0] frm[2][64];
  int          gp[2][64];
  logic [7:0]  mem[2][256];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int rdw, p;
      rdw = (i == 0) ? 2 : 3;
      if (vr[i]) nvr[i]++;
      if (wd[i]) nwd[i]++;
      if (vr[i] && wd[i]) both_bad[i]++;
      if (!ssn[i]) begin
        if (idx[i] == 0) begin
          if (seen[i]) begin
            gp[i][gcnt[i] % 64] = hi_run[i];
            gcnt[i]++;
          end
          fb[i] = '0;
        end
        hi_run[i] = 0;
        if (idx[i] < 11) fb[i] = {fb[i][9:0], mosi[i]};
        else if (mosi[i]) mosi_bad[i]++;
        p = idx[i] - 11 - rdw;
        if (idx[i] >= 11 && fb[i][9:8] == 2'b11 && p >= 0 && p < 8)
          miso[i] = mem[i][maddr[i]][7-p];
        else
          miso[i] = 1'b0;
        idx[i]++;
      end else begin
        if (mosi[i]) mosi_bad[i]++;
        miso[i] = 1'b0;
        if (idx[i] >= 11) begin
          frm[i][fcnt[i] % 64] = fb[i];
          fcnt[i]++;
          seen[i] = 1'b1;
          case (fb[i][9:8])
            2'b00, 2'b10: maddr[i] = fb[i][7:0];
            2'b01:        mem[i][maddr[i]] = fb[i][7:0];
            default: ;
          endcase
        end
        idx[i] = 0;
        hi_run[i]++;
      end
    end
  end

  int nchk = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] lastf(input int i, input int k, input int n);
    return frm[i][(fcnt[i] - n + k) % 64];
  endfunction

  function automatic int lastg(input int i, input int k, input int n);
    return gp[i][(gcnt[i] - n + k) % 64];
  endfunction

  // Single request; inputs are scrambled and req_valid toggled while busy.
  task automatic do_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input int exp_cyc, input logic [7:0] exp_rd, input string tag);
    int c;
    bit done;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(rdy[i]), 32'd1);
    rv[i] = 1'b1; rw[i] = wr; ra[i] = a; rd[i] = d;
    @(posedge clk); #1;
    rv[i] = 1'b0; rw[i] = ~wr; ra[i] = ~a; rd[i] = ~d;
    c = 0; done = 1'b0;
    while (!done && c < 200) begin
      @(negedge clk); c++;
      if (c == 2) chk({tag, "_busy_ready"}, 32'(rdy[i]), 32'd0);
      if (wr ? wd[i] : vr[i]) done = 1'b1;
      else begin
        rv[i] = (c < 18) ? c[0] : 1'b0;
        ra[i] = 8'($urandom);
      end
    end
    rv[i] = 1'b0;
    chk({tag, "_cycle"}, 32'(c), 32'(exp_cyc));
    if (!wr) chk({tag, "_rdata"}, 32'(rdat[i]), 32'(exp_rd));
    @(negedge clk);
  endtask

  // Write then read with req_valid held high across the boundary.
  task automatic btb(input int i, input logic [7:0] a, input logic [7:0] d, input int gap,
                     input string tag);
    int c;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(rdy[i]), 32'd1);
    rv[i] = 1'b1; rw[i] = 1'b1; ra[i] = a; rd[i] = d;
    @(posedge clk);
    c = 0;
    do begin @(negedge clk); c++; end while (!wd[i] && c < 200);
    chk({tag, "_wr_done"}, 32'(wd[i]), 32'd1);
    rw[i] = 1'b0;
    c = 0;
    while (!rdy[i] && c < 50) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    rv[i] = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!vr[i] && c < 200);
    chk({tag, "_rsp_valid"}, 32'(vr[i]), 32'd1);
    chk({tag, "_rdata"}, 32'(rdat[i]), 32'(d));
    @(negedge clk);
    chk({tag, "_f0"}, 32'(lastf(i, 0, 4)), 32'({1'b0, 2'b00, a}));
    chk({tag, "_f1"}, 32'(lastf(i, 1, 4)), 32'({1'b0, 2'b01, d}));
    chk({tag, "_f2"}, 32'(lastf(i, 2, 4)), 32'({1'b1, 2'b10, a}));
    chk({tag, "_f3"}, 32'(lastf(i, 3, 4)), 32'({1'b1, 2'b11, 8'h00}));
    for (int k = 0; k < 3; k++) chk({tag, "_gap"}, 32'(lastg(i, k, 3)), 32'(gap));
  endtask

  initial begin
    int v0, w0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 8'h00; rd[i] = 8'h00;
    end
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ss_n", 32'(ssn[0]), 32'd1);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_rsp_valid", 32'(vr[0]), 32'd0);
    chk("rst_wr_done", 32'(wd[0]), 32'd0);
    chk("rst_rdata", 32'(rdat[0]), 32'd0);
    chk("rst_ready1", 32'(rdy[1]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy[0]), 32'd1);

    // Write 0x5A <- 0x3C, then read it back
    do_req(0, 1'b1, 8'h5A, 8'h3C, 24, 8'h00, "wr");
    chk("wr_fA", 32'(lastf(0, 0, 2)), 32'({1'b0, 2'b00, 8'h5A}));
    chk("wr_fB", 32'(lastf(0, 1, 2)), 32'({1'b0, 2'b01, 8'h3C}));
    chk("wr_gap", 32'(lastg(0, 0, 1)), 32'd1);
    do_req(0, 1'b0, 8'h5A, 8'h00, 34, 8'h3C, "rd");
    chk("rd_fA", 32'(lastf(0, 0, 2)), 32'({1'b1, 2'b10, 8'h5A}));
    chk("rd_fB", 32'(lastf(0, 1, 2)), 32'({1'b1, 2'b11, 8'h00}));
    chk("rd_gap", 32'(lastg(0, 0, 1)), 32'd1);

    // Back-to-back write/read
    btb(0, 8'h11, 8'hA5, 1, "btb0");

    // Reset during cycle 7 of a read
    v0 = nvr[0]; w0 = nwd[0];
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 8'h5A;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_ss_low", 32'(ssn[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ss_high", 32'(ssn[0]), 32'd1);
    chk("abort_mosi", 32'(mosi[0]), 32'd0);
    chk("abort_ready_in_rst", 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(rdy[0]), 32'd1);
    repeat (40) @(negedge clk);
    chk("abort_no_rsp", 32'(nvr[0] - v0), 32'd0);
    chk("abort_no_wd", 32'(nwd[0] - w0), 32'd0);
    chk("abort_ss_idle", 32'(ssn[0]), 32'd1);

    // RD_WAIT=3, GAP_CYCLES=2 instance
    btb(1, 8'h5A, 8'h3C, 2, "btb1");
    do_req(1, 1'b0, 8'h5A, 8'h00, 36, 8'h3C, "rd1");
    chk("rd1_gap", 32'(lastg(1, 0, 1)), 32'd2);
    do_req(1, 1'b1, 8'h22, 8'h77, 25, 8'h00, "wr1");
    chk("wr1_fB", 32'(lastf(1, 1, 2)), 32'({1'b0, 2'b01, 8'h77}));

    // Global protocol properties
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("mosi_idle_zero", 32'(mosi_bad[i]), 32'd0);
      chk("rsp_wd_overlap", 32'(both_bad[i]), 32'd0);
    end
    chk("n_rsp0", 32'(nvr[0]), 32'd2);
    chk("n_wd0", 32'(nwd[0]), 32'd2);
    chk("n_rsp1", 32'(nvr[1]), 32'd2);
    chk("n_wd1", 32'(nwd[1]), 32'd2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
